// File: rtl/vmem0_ctl.sv
// vmem0_ctl: sequencer for the 2048x5 map stage-0 RAM: host read/write plus a
// full-table fill pass.
module vmem0_ctl #(
  parameter logic [4:0] FILL_VALUE = 5'h1F,
  parameter logic       AUTO_INIT  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [10:0] req_adr,
  input  logic [4:0]  req_data,
  output logic        rsp_valid,
  output logic [4:0]  rsp_data,
  output logic [10:0] vm0_adr,
  output logic [4:0]  vm0_wdata,
  output logic        vm0wp,
  output logic        vm0rp,
  input  logic [4:0]  vmap,
  output logic        fill_busy,
  output logic        fill_done
);
  typedef enum logic [2:0] {IDLE, WR, RD, CAP, FILL} state_t;
  state_t state_q, state_d;
  logic [10:0] cnt_q, cnt_d, adr_q, adr_d;
  logic [4:0] wdata_q, wdata_d, rsp_q, rsp_d;
  logic live_q, rsp_v_q, rsp_v_d, done_q, done_d, acc, fill_go, last;
  assign req_ready = live_q && state_q == IDLE;
  assign acc = req_valid && req_ready;
  assign last = cnt_q == 11'h7FF;
  // live_q keeps the controller from accepting on the very first edge after reset
  assign fill_go = (state_q == IDLE && !live_q && AUTO_INIT) || (acc && req_op == 2'b10);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    adr_d = adr_q;
    wdata_d = wdata_q;
    rsp_d = state_q == CAP ? vmap : rsp_q;
    rsp_v_d = state_q == CAP;
    done_d = state_q == FILL && last;
    if (fill_go) begin
      state_d = FILL;
      cnt_d = '0;
      adr_d = '0;
      wdata_d = FILL_VALUE;
    end else if (acc) begin
      state_d = req_op == 2'b01 ? WR : RD;
      adr_d = req_adr;
      wdata_d = req_op == 2'b01 ? req_data : wdata_q;
    end else if (state_q == FILL) begin
      cnt_d = cnt_q + 11'd1;
      adr_d = last ? adr_q : cnt_q + 11'd1;
      state_d = last ? IDLE : FILL;
    end else begin
      state_d = state_q == RD ? CAP : IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      adr_q <= '0;
      wdata_q <= '0;
      rsp_q <= '0;
      rsp_v_q <= 1'b0;
      done_q <= 1'b0;
      live_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      adr_q <= adr_d;
      wdata_q <= wdata_d;
      rsp_q <= rsp_d;
      rsp_v_q <= rsp_v_d;
      done_q <= done_d;
      live_q <= 1'b1;
    end
  end
  assign vm0_adr = adr_q;
  assign vm0_wdata = wdata_q;
  assign vm0wp = state_q == WR || state_q == FILL;
  assign vm0rp = state_q == RD;
  assign fill_busy = state_q == FILL;
  assign fill_done = done_q;
  assign rsp_valid = rsp_v_q;
  assign rsp_data = rsp_q;
endmodule
